// File: rtl/instr_decode_reg.sv
// rtl/instr_decode_reg.sv - IF/ID decode register with 2-entry skid buffer and flush
//
// Registers each fetched instruction with its PC and presents the decoded
// fields (opcode, rd, rs, rt, imm) to execute. A main/skid register pair lets
// fetch keep transferring through a one-cycle downstream stall, and flush
// squashes every held instruction on a taken branch.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid     fetch offers in_instr/in_pc
//   in_ready     stage can accept (low only when both entries are occupied)
//   in_instr     fetched instruction
//   in_pc        PC of in_instr
//   flush        drop all held instructions and any same-cycle input
//   out_valid    decoded fields are valid
//   out_ready    execute accepts the presented instruction
//   out_opcode   instr[15:12]
//   out_rd       instr[11:8]
//   out_rs       instr[7:4]
//   out_rt       instr[3:0]
//   out_imm      instr[IMM_SIZE-1:0], feeds the sign extender
//   out_pc       PC of the presented instruction
module instr_decode_reg #(
    parameter int INSTR_SIZE = 16,
    parameter int IMM_SIZE   = 8,
    parameter int ADDR_SIZE  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_SIZE-1:0] in_instr,
    input  logic [ADDR_SIZE-1:0]  in_pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            out_opcode,
    output logic [3:0]            out_rd,
    output logic [3:0]            out_rs,
    output logic [3:0]            out_rt,
    output logic [IMM_SIZE-1:0]   out_imm,
    output logic [ADDR_SIZE-1:0]  out_pc
);

    // Occupancy encoding: EMPTY = no entry, FULL = main only, SKID = main + skid.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [INSTR_SIZE-1:0] main_instr_q, main_instr_d;
    logic [ADDR_SIZE-1:0]  main_pc_q, main_pc_d;
    logic [INSTR_SIZE-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_SIZE-1:0]  skid_pc_q, skid_pc_d;

    logic main_valid;
    logic skid_valid;
    logic acc;
    logic pop;

    assign main_valid = (state_q == ST_FULL) || (state_q == ST_SKID);
    assign skid_valid = (state_q == ST_SKID);

    // Depends on registered state only, so there is no out_ready -> in_ready path.
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    main_instr_d = in_instr;
                    main_pc_d    = in_pc;
                    state_d      = ST_FULL;
                end
            end
            ST_FULL: begin
                if (pop && acc) begin
                    main_instr_d = in_instr;
                    main_pc_d    = in_pc;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end else if (acc) begin
                    // Main is stalled: park the new instruction behind it.
                    skid_instr_d = in_instr;
                    skid_pc_d    = in_pc;
                    state_d      = ST_SKID;
                end
            end
            ST_SKID: begin
                if (pop) begin
                    main_instr_d = skid_instr_q;
                    main_pc_d    = skid_pc_q;
                    state_d      = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Clearing the occupancy is enough to squash everything; stale data in
        // the registers is never presented because out_valid drops with it.
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= '0;
            main_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign out_opcode = main_instr_q[15:12];
    assign out_rd     = main_instr_q[11:8];
    assign out_rs     = main_instr_q[7:4];
    assign out_rt     = main_instr_q[3:0];
    assign out_imm    = main_instr_q[IMM_SIZE-1:0];
    assign out_pc     = main_pc_q;

endmodule

// File: tb/tb_instr_decode_reg.sv
// tb/tb_instr_decode_reg.sv - self-checking bench for instr_decode_reg
module tb_instr_decode_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [3:0]  out_rd;
    logic [3:0]  out_rs;
    logic [3:0]  out_rt;
    logic [7:0]  out_imm;
    logic [15:0] out_pc;

    int n_vec;
    int n_err;

    // Reference: ordered list of {instr, pc} currently held by the stage.
    logic [31:0] model_q[$];

    instr_decode_reg #(
        .INSTR_SIZE(16),
        .IMM_SIZE  (8),
        .ADDR_SIZE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_opcode(out_opcode),
        .out_rd    (out_rd),
        .out_rs    (out_rs),
        .out_rt    (out_rt),
        .out_imm   (out_imm),
        .out_pc    (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the model across the clock edge,
    // and return 1 ns after the edge so outputs can be sampled.
    task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] p,
                        input logic fl, input logic ordy, input logic r);
        logic m_acc;
        logic m_pop;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = p;
        flush     = fl;
        out_ready = ordy;
        rst       = r;
        m_acc = v && (model_q.size() < 2);
        m_pop = ordy && (model_q.size() > 0);
        @(posedge clk);
        if (r || fl) begin
            model_q.delete();
        end else begin
            if (m_pop) void'(model_q.pop_front());
            if (m_acc) model_q.push_back({ins, p});
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_vec++;
        if ({out_opcode, out_rd, out_rs, out_rt, out_imm, out_pc} !== 40'h0) begin
            n_err++;
            $display("FAIL reset_fields got %h want 0", {out_opcode, out_rd, out_rs, out_rt, out_imm, out_pc});
        end
    endtask

    task automatic test_basic();
        step(1'b1, 16'h1A5F, 16'h0010, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if ({out_valid, out_opcode, out_rd, out_rs, out_rt, out_imm, out_pc} !== {1'b1, 4'h1, 4'hA, 4'h5, 4'hF, 8'h5F, 16'h0010}) begin
            n_err++;
            $display("FAIL basic_decode got v=%b op=%h rd=%h rs=%h rt=%h imm=%h pc=%h want v=1 op=1 rd=A rs=5 rt=F imm=5F pc=0010",
                     out_valid, out_opcode, out_rd, out_rs, out_rt, out_imm, out_pc);
        end
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq[3];
        seq[0] = 16'hA001; seq[1] = 16'hB002; seq[2] = 16'hC003;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d] got %b want 1", k, in_ready); end
            step(1'b1, seq[k], 16'h0100 + 16'(k), 1'b0, 1'b1, 1'b0);
            n_vec++;
            if ({out_valid, out_opcode, out_rd, out_rs, out_rt, out_pc} !== {1'b1, seq[k], 16'h0100 + 16'(k)}) begin
                n_err++;
                $display("FAIL b2b_out[%0d] got v=%b instr=%h pc=%h want v=1 instr=%h pc=%h", k, out_valid,
                         {out_opcode, out_rd, out_rs, out_rt}, out_pc, seq[k], 16'h0100 + 16'(k));
            end
        end
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        step(1'b1, 16'h1111, 16'h0001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h2222, 16'h0002, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready_full got %b want 0", in_ready); end
        step(1'b1, 16'h3333, 16'h0003, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({out_valid, out_opcode, out_rd, out_rs, out_rt, in_ready} !== {1'b1, 16'h1111, 1'b0}) begin
            n_err++;
            $display("FAIL stall_hold got v=%b instr=%h rdy=%b want v=1 instr=1111 rdy=0", out_valid,
                     {out_opcode, out_rd, out_rs, out_rt}, in_ready);
        end
        step(1'b1, 16'h3333, 16'h0003, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if ({out_valid, out_opcode, out_rd, out_rs, out_rt, out_pc, in_ready} !== {1'b1, 16'h2222, 16'h0002, 1'b1}) begin
            n_err++;
            $display("FAIL stall_drain1 got v=%b instr=%h pc=%h rdy=%b want v=1 instr=2222 pc=0002 rdy=1", out_valid,
                     {out_opcode, out_rd, out_rs, out_rt}, out_pc, in_ready);
        end
        step(1'b1, 16'h3333, 16'h0003, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if ({out_valid, out_opcode, out_rd, out_rs, out_rt, out_pc} !== {1'b1, 16'h3333, 16'h0003}) begin
            n_err++;
            $display("FAIL stall_third got v=%b instr=%h pc=%h want v=1 instr=3333 pc=0003", out_valid,
                     {out_opcode, out_rd, out_rs, out_rt}, out_pc);
        end
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_empty got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        step(1'b1, 16'h4001, 16'h0041, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h4002, 16'h0042, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h4444, 16'h0044, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL flush_state got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_ghost got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 16'h5555, 16'h0055, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if ({out_valid, out_opcode, out_rd, out_rs, out_rt, out_imm, out_pc} !== 41'h0) begin
            n_err++;
            $display("FAIL rst_mid got v=%b instr=%h pc=%h want all 0", out_valid,
                     {out_opcode, out_rd, out_rs, out_rt}, out_pc);
        end
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_after got %b want 0", out_valid); end
    endtask

    task automatic test_neg_imm();
        logic [15:0] sext;
        step(1'b1, 16'h7380, 16'h0200, 1'b0, 1'b1, 1'b0);
        sext = {{8{out_imm[7]}}, out_imm};
        n_vec++;
        if (out_imm !== 8'h80) begin n_err++; $display("FAIL neg_imm got %h want 80", out_imm); end
        n_vec++;
        if (sext !== 16'hFF80) begin n_err++; $display("FAIL neg_sext got %h want FF80", sext); end
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic        v, fl, ordy, r;
        logic [15:0] ins, p;
        logic [15:0] e_instr;
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            r    = ($urandom_range(0, 63) == 0);
            ins  = 16'($urandom);
            p    = 16'($urandom);
            step(v, ins, p, fl, ordy, r);
            n_vec++;
            if (out_valid !== (model_q.size() > 0)) begin
                n_err++;
                $display("FAIL rand_valid[%0d] got %b want %b", i, out_valid, model_q.size() > 0);
            end
            n_vec++;
            if (in_ready !== (model_q.size() < 2)) begin
                n_err++;
                $display("FAIL rand_ready[%0d] got %b want %b", i, in_ready, model_q.size() < 2);
            end
            if (model_q.size() > 0) begin
                e_instr = model_q[0][31:16];
                n_vec++;
                if ({out_opcode, out_rd, out_rs, out_rt, out_imm, out_pc} !==
                    {4'((e_instr >> 12) & 16'hF), 4'((e_instr >> 8) & 16'hF), 4'((e_instr >> 4) & 16'hF),
                     4'(e_instr & 16'hF), 8'(e_instr % 256), model_q[0][15:0]}) begin
                    n_err++;
                    $display("FAIL rand_fields[%0d] got instr=%h imm=%h pc=%h want instr=%h pc=%h", i,
                             {out_opcode, out_rd, out_rs, out_rt}, out_imm, out_pc, e_instr, model_q[0][15:0]);
                end
            end else if (r) begin
                n_vec++;
                if ({out_opcode, out_rd, out_rs, out_rt, out_imm, out_pc} !== 40'h0) begin
                    n_err++;
                    $display("FAIL rand_rst_fields[%0d] got %h want 0", i,
                             {out_opcode, out_rd, out_rs, out_rt, out_imm, out_pc});
                end
            end
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid();
        test_neg_imm();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
